// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the mem_responder slice: the responder FSM state
// encoding, the default parameter values and the latency-counter helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    // Responder FSM: accept in IDLE, count down in WAIT, hold the response in RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 4;

    // Wide enough for the largest legal latency (15).
    localparam int CNT_W = 4;

    // The counter is loaded at acceptance and WAIT exits when it reads zero,
    // so LATENCY-1 gives exactly LATENCY edges from acceptance to RESP.
    function automatic logic [CNT_W-1:0] latencyLoad(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// ---------------------------------------------------------------------------
// mem_resp_array
// Single-port DEPTH x DATA_W storage: synchronous write, asynchronous read on
// the same address. The contents are deliberately not reset.
// Ports:
//   clk      - write clock
//   i_we     - write enable (commit i_wdata at i_addr on the rising edge)
//   i_addr   - word index, shared by read and write
//   i_wdata  - write data
//   o_rdata  - combinational read of the word at i_addr
// ---------------------------------------------------------------------------
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Fixed-latency memory responder for a cache. A request is accepted in IDLE;
// a write is committed on the acceptance edge and a read samples the array at
// that same edge. After LATENCY cycles the response is presented and held
// until the cache takes it with resp_ready.
//
// Optional feature macro: MEM_RESPONDER_ERR_EN
//   defined   - adds resp_err; requests with nonzero address bits at or above
//               log2(DEPTH) are flagged, writes suppressed, rdata returned 0.
//   undefined - no resp_err port; addresses alias modulo DEPTH.
//
// Ports:
//   clk         - sole clock, rising edge
//   reset       - asynchronous, active-low reset
//   req_valid   - request present
//   req_ready   - responder can accept (IDLE only, from first edge after reset)
//   req_we      - 1 = write, 0 = read
//   req_addr    - word address
//   req_wdata   - write data
//   resp_valid  - response available
//   resp_ready  - cache accepts the response
//   resp_rdata  - read data; 0 for writes and whenever resp_valid is 0
//   resp_err    - address error flag (MEM_RESPONDER_ERR_EN only)
// ---------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata
`ifdef MEM_RESPONDER_ERR_EN
    ,
    output logic              resp_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = latencyLoad(LATENCY);

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_readyEn;
    logic              w_accept;
    logic              w_addrErr;
    logic              w_memWe;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_memRdata;
`ifdef MEM_RESPONDER_ERR_EN
    logic              r_err;
`endif

    assign w_idx    = req_addr[IDX_W-1:0];
    assign w_accept = req_valid && req_ready;

    // Any address bit beyond the index range marks the request as erroneous.
`ifdef MEM_RESPONDER_ERR_EN
    assign w_addrErr = (req_addr >> IDX_W) != '0;
`else
    logic [ADDR_W-1:0] w_unusedAddrHi;
    assign w_unusedAddrHi = req_addr >> IDX_W;
    assign w_addrErr      = 1'b0;
`endif

    // Writes land on the acceptance edge so a following read always sees them.
    assign w_memWe = w_accept && req_we && !w_addrErr;

    mem_resp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_memWe),
        .i_addr  (w_idx),
        .i_wdata (req_wdata),
        .o_rdata (w_memRdata)
    );

    // State register plus response datapath. r_readyEn holds req_ready low
    // until the first edge after reset releases. Read data is captured at
    // acceptance so later writes cannot disturb an in-flight response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_readyEn <= 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_nextState;
            r_readyEn <= 1'b1;
            if (w_accept) begin
                r_cnt   <= LAT_LOAD;
                r_rdata <= (req_we || w_addrErr) ? '0 : w_memRdata;
`ifdef MEM_RESPONDER_ERR_EN
                r_err   <= w_addrErr;
`endif
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Next-state logic. resp_ready only matters in RESP, so an early ready
    // from the cache cannot shorten the latency.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)        w_nextState = ST_WAIT;
            ST_WAIT: if (r_cnt == '0)     w_nextState = ST_RESP;
            ST_RESP: if (resp_ready)      w_nextState = ST_IDLE;
            default:                      w_nextState = ST_IDLE;
        endcase
    end

    // Outputs are gated by state so rdata and err read zero outside RESP.
    always_comb begin
        req_ready  = (r_state == ST_IDLE) && r_readyEn;
        resp_valid = (r_state == ST_RESP);
        resp_rdata = resp_valid ? r_rdata : '0;
`ifdef MEM_RESPONDER_ERR_EN
        resp_err   = resp_valid ? r_err : 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Three responders share clock and reset:
//   dut 0: DEPTH 256, LATENCY 4   (main function, backpressure, reset abort)
//   dut 1: DEPTH 16,  LATENCY 1   (address error / aliasing, minimum latency)
//   dut 2: DEPTH 256, LATENCY 15  (maximum latency)
// Inputs are driven on the falling edge and outputs sampled there.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    logic       reqValid  [N];
    logic       reqWe     [N];
    logic       respReady [N];
    logic [7:0] reqAddr   [N];
    logic [7:0] reqWdata  [N];
    logic       reqReady  [N];
    logic       respValid [N];
    logic [7:0] respRdata [N];
`ifdef MEM_RESPONDER_ERR_EN
    logic       respErr   [N];
`endif

    int checks = 0;
    int errors = 0;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(4)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]), .resp_rdata(respRdata[0])
`ifdef MEM_RESPONDER_ERR_EN
        , .resp_err(respErr[0])
`endif
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]), .resp_rdata(respRdata[1])
`ifdef MEM_RESPONDER_ERR_EN
        , .resp_err(respErr[1])
`endif
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(15)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_we(reqWe[2]),
        .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
        .resp_valid(respValid[2]), .resp_ready(respReady[2]), .resp_rdata(respRdata[2])
`ifdef MEM_RESPONDER_ERR_EN
        , .resp_err(respErr[2])
`endif
    );

    typedef struct {
        int         dut;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         stall;
        bit         early;
        logic [7:0] expData;
        bit         expErr;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic int latOf(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic void addVec(input int d, input bit we, input logic [7:0] addr,
                                   input logic [7:0] wdata, input int stall, input bit early,
                                   input logic [7:0] expData, input bit expErr, input string name);
        vec_t v;
        v.dut = d; v.we = we; v.addr = addr; v.wdata = wdata; v.stall = stall;
        v.early = early; v.expData = expData; v.expErr = expErr; v.name = name;
        vecs.push_back(v);
    endfunction

    // One comparison: count it, and report a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full request/response transaction on one dut. Called just after a
    // falling edge with that dut idle; returns just after the falling edge
    // that follows the response handshake.
    task automatic applyStimulus(input int d, input bit we, input logic [7:0] addr,
                                 input logic [7:0] wdata, input int stall, input bit early,
                                 output logic [7:0] rdata, output logic err, output int lat);
        bit quiet;
        bit stable;
        reqValid[d]  = 1'b1;
        reqWe[d]     = we;
        reqAddr[d]   = addr;
        reqWdata[d]  = wdata;
        respReady[d] = early;
        err          = 1'b0;
        checkOutput("ready at issue", {31'd0, reqReady[d]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0;
        lat   = 0;
        quiet = 1'b1;
        while (!respValid[d] && lat < 40) begin
            if (reqReady[d] || respRdata[d] != 8'h00) quiet = 1'b0;
            lat++;
            @(negedge clk);
        end
        checkOutput("quiet while waiting", {31'd0, quiet}, 32'd1);
        checkOutput("resp valid arrives", {31'd0, respValid[d]}, 32'd1);
        rdata = respRdata[d];
`ifdef MEM_RESPONDER_ERR_EN
        err = respErr[d];
`endif
        if (!respValid[d]) return;
        if (stall > 0) begin
            respReady[d] = 1'b0;
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!respValid[d] || respRdata[d] !== rdata || reqReady[d]) stable = 1'b0;
            end
            checkOutput("stable under backpressure", {31'd0, stable}, 32'd1);
        end
        respReady[d] = 1'b1;
        @(negedge clk);
        respReady[d] = 1'b0;
        checkOutput("valid low after handshake", {31'd0, respValid[d]}, 32'd0);
        checkOutput("idle after handshake", {31'd0, reqReady[d]}, 32'd1);
        checkOutput("rdata zero after handshake", {24'd0, respRdata[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rdata;
        logic       err;
        int         lat;
        bit         noResp;
        bit         errMode;

`ifdef MEM_RESPONDER_ERR_EN
        errMode = 1'b1;
`else
        errMode = 1'b0;
`endif

        for (int i = 0; i < N; i++) begin
            reqValid[i] = 1'b0; reqWe[i] = 1'b0; respReady[i] = 1'b0;
            reqAddr[i]  = 8'h00; reqWdata[i] = 8'h00;
        end

        // dut 0: write/read, back-to-back with ready tied, backpressure.
        addVec(0, 1'b1, 8'h10, 8'hAA, 0, 1'b0, 8'h00, 1'b0, "write 0x10");
        addVec(0, 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'hAA, 1'b0, "read 0x10");
        addVec(0, 1'b1, 8'h01, 8'h55, 0, 1'b1, 8'h00, 1'b0, "b2b write 0x01");
        addVec(0, 1'b1, 8'h02, 8'h66, 0, 1'b1, 8'h00, 1'b0, "b2b write 0x02");
        addVec(0, 1'b0, 8'h01, 8'h00, 0, 1'b1, 8'h55, 1'b0, "b2b read 0x01");
        addVec(0, 1'b0, 8'h02, 8'h00, 0, 1'b1, 8'h66, 1'b0, "b2b read 0x02");
        addVec(0, 1'b0, 8'h10, 8'h00, 7, 1'b0, 8'hAA, 1'b0, "backpressure read 0x10");
        // dut 1: DEPTH 16, out-of-range address 0x13 against index 0x03.
        addVec(1, 1'b1, 8'h03, 8'h11, 0, 1'b0, 8'h00, 1'b0, "d16 write 0x03");
        addVec(1, 1'b1, 8'h13, 8'h77, 0, 1'b0, 8'h00, errMode, "d16 write 0x13");
        addVec(1, 1'b0, 8'h03, 8'h00, 0, 1'b0, errMode ? 8'h11 : 8'h77, 1'b0, "d16 read 0x03");
        addVec(1, 1'b0, 8'h13, 8'h00, 0, 1'b0, errMode ? 8'h00 : 8'h77, errMode, "d16 read 0x13");
        addVec(1, 1'b1, 8'h0F, 8'h22, 0, 1'b1, 8'h00, 1'b0, "d16 write 0x0F");
        addVec(1, 1'b0, 8'h0F, 8'h00, 0, 1'b1, 8'h22, 1'b0, "d16 read 0x0F");
        // dut 2: maximum latency.
        addVec(2, 1'b1, 8'h05, 8'h3C, 0, 1'b0, 8'h00, 1'b0, "lat15 write 0x05");
        addVec(2, 1'b0, 8'h05, 8'h00, 0, 1'b1, 8'h3C, 1'b0, "lat15 read 0x05");

        // Reset state while asserted, then ready only after the first edge.
        #3;
        for (int i = 0; i < N; i++) begin
            checkOutput("reset req_ready", {31'd0, reqReady[i]}, 32'd0);
            checkOutput("reset resp_valid", {31'd0, respValid[i]}, 32'd0);
            checkOutput("reset resp_rdata", {24'd0, respRdata[i]}, 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("ready held before first edge", {31'd0, reqReady[0]}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checkOutput("ready after first edge", {31'd0, reqReady[i]}, 32'd1);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].stall, vecs[i].early, rdata, err, lat);
            checkOutput({vecs[i].name, " latency"}, lat, latOf(vecs[i].dut));
            checkOutput({vecs[i].name, " rdata"}, {24'd0, rdata}, {24'd0, vecs[i].expData});
`ifdef MEM_RESPONDER_ERR_EN
            checkOutput({vecs[i].name, " err"}, {31'd0, err}, {31'd0, vecs[i].expErr});
`endif
        end

        // Reset two cycles into the WAIT of a read: no response may appear,
        // and the array keeps its contents.
        reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 8'h10; respReady[0] = 1'b1;
        checkOutput("abort read ready", {31'd0, reqReady[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort valid during reset", {31'd0, respValid[0]}, 32'd0);
        checkOutput("abort ready during reset", {31'd0, reqReady[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        noResp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (respValid[0]) noResp = 1'b0;
        end
        respReady[0] = 1'b0;
        checkOutput("no response after abort", {31'd0, noResp}, 32'd1);
        checkOutput("idle after abort", {31'd0, reqReady[0]}, 32'd1);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 0, 1'b0, rdata, err, lat);
        checkOutput("reissued read latency", lat, 4);
        checkOutput("reissued read rdata", {24'd0, rdata}, 32'h0000_00AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
